inst_rom: RTL and testbench
===========================

# inst_rom

Instruction memory responder for the five-stage MIPS core. It answers the fetch port (`rom_ce`/`rom_addr` → `rom_data`) with a combinational read, so the IF/ID register captures the instruction in the same cycle the PC presents it. It also has a byte-serial program-load port that assembles big-endian words and writes them sequentially from word 0. While a load is in progress it raises a busy flag so the CPU can be held in reset.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; depth is 2^ADDR_WIDTH words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rom_ce_i`  in  1  fetch enable from the PC stage.
- `rom_addr_i`  in  32  fetch byte address.
- `rom_data_o`  out  32  instruction word, combinational.
- `load_start_i`  in  1  begin or restart a program load.
- `load_valid_i`  in  1  a load byte is present.
- `load_byte_i`  in  8  load byte; first byte of each word goes to bits [31:24].
- `load_last_i`  in  1  qualifies the final byte of the image.
- `load_ready_o`  out  1  loader accepts a byte this cycle.
- `load_busy_o`  out  1  a load is in progress.
- `load_words_o`  out  ADDR_WIDTH+1  words written since the last start.
- `load_err_o`  out  1  sticky error: partial final word or overflow.
- `load_sum_o`  out  32  present only with `INST_ROM_CHECKSUM_EN`.

## Operation
**Read path**
- `rom_data_o` = `mem[rom_addr_i[ADDR_WIDTH+1:2]]` when `rom_ce_i`=1, else 0.
- Bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so high addresses alias.

**Loader FSM: IDLE, LOAD, ERR**
- IDLE: `load_ready_o`=0. On `load_start_i` go to LOAD and clear the word pointer, byte count, `load_words_o`, `load_err_o` and the checksum.
- LOAD: `load_ready_o`=1. A byte is accepted on `load_valid_i & load_ready_o` and shifted into the assembly register.
  - On the 4th byte: write the word to `mem[ptr]`, then increment `ptr` and `load_words_o`.
  - Accepted byte with `load_last_i`=1 that completes a word: write it, go to IDLE.
  - Accepted byte with `load_last_i`=1 mid-word: zero-fill the remaining low bytes, write, set `load_err_o`, go to IDLE.
  - Byte accepted after 2^ADDR_WIDTH words are written: drop it, set `load_err_o`, go to ERR.
- ERR: `load_ready_o`=0. `load_start_i` goes to LOAD with the same clears as from IDLE.
- `load_start_i` during LOAD restarts the load and discards any partial word. `load_start_i` has priority over a byte accepted in the same cycle.
- `load_busy_o` = (state == LOAD).
- Memory contents are never reset; only control state is reset.

## Timing
- Reset values: state IDLE; `load_ready_o` 0, `load_busy_o` 0, `load_words_o` 0, `load_err_o` 0, `load_sum_o` 0.
- `rom_data_o` follows `rom_ce_i`, `rom_addr_i` and memory contents with zero latency.
- A word is written on the edge that accepts its final byte. It is readable from the following cycle.
- Read-during-write to the same address returns the old word until the edge.
- Throughput is 1 byte per cycle, so 4 cycles per word.
- `load_busy_o` rises the cycle after `load_start_i` and falls the cycle after the last byte is accepted.
- Reset asserted mid-load: go to IDLE immediately; the partial word is lost; words already written are kept.

## Configuration
- `INST_ROM_CHECKSUM_EN` defined: `load_sum_o` is a 32-bit wrapping sum of every word written since the last start. It is updated on the same edge as the write and cleared on start and on reset.
- Macro undefined: the `load_sum_o` port and its adder are absent; all other behaviour is identical.

## Structure
- `defines.v` holds:
  - the loader state encodings `InstRomIdle`, `InstRomLoad`, `InstRomErr`;
  - the existing `ZeroWord` constant;
  - the default `InstRomAddrWidth`.
- Sub-module `inst_rom_loader` contains the FSM, byte assembly, pointer and checksum. It emits `we`, `waddr`, `wdata`.
- `inst_rom` owns the memory array and the combinational read port.

## Test plan
- **Single-word load.** Reset, start, bytes 0x34,0x01,0x12,0x34 with last on the 4th → read addr 0x0, ce=1 returns 0x34011234; `load_words_o`=1; `load_err_o`=0; busy low the next cycle.
- **Two-word load and read port.** Load 8 bytes forming 0x20010005 and 0x20020007 → addr 0x4 and 0x5 both return 0x20020007; `rom_ce_i`=0 returns 0.
- **Partial final word.** Start, bytes 0xAB,0xCD with last on the 2nd → mem[0]=0xABCD0000, `load_err_o`=1, state IDLE.
- **Overflow.** ADDR_WIDTH=2, 17 bytes → 4 words written, 17th byte dropped, ERR, ready=0, err=1. A new start clears err and reaches LOAD.
- **Reset mid-load.** Assert `rst` after 6 bytes → busy=0, words=0; mem[0] keeps the first word; mem[1] is unchanged.
- **Checksum (`INST_ROM_CHECKSUM_EN`).** Load words 0xFFFFFFFF and 0x00000002 → `load_sum_o`=0x00000001.

Source files
------------

// File: rtl/inst_rom_pkg.sv
// Shared types and constants for the instruction ROM and its program loader.
// Loader state encodings, the zero word and the default address width live here.
package inst_rom_pkg;

  localparam int          InstRomAddrWidth = 10;
  localparam logic [31:0] ZeroWord         = 32'h0000_0000;

  typedef enum logic [1:0] {
    InstRomIdle = 2'd0,
    InstRomLoad = 2'd1,
    InstRomErr  = 2'd2
  } inst_rom_state_e;

  // Big-endian byte placement: byte index 0 lands in bits [31:24].
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [7:0]  data,
                                             input logic [1:0]  idx);
    return word | (32'(data) << {idx ^ 2'b11, 3'b000});
  endfunction

endpackage

// File: rtl/inst_rom_loader.sv
// Byte-serial program loader: assembles big-endian words and emits sequential writes.
// With INST_ROM_CHECKSUM_EN defined it also keeps a wrapping sum of written words.
module inst_rom_loader
  import inst_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = InstRomAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic [7:0]            load_byte_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic                  load_busy_o,
  output logic [ADDR_WIDTH:0]   load_words_o,
  output logic                  load_err_o,
`ifdef INST_ROM_CHECKSUM_EN
  output logic [31:0]           load_sum_o,
`endif
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [31:0]           wdata_o
);

  inst_rom_state_e      state_q;
  logic [1:0]           byte_cnt_q;
  logic [31:0]          word_q;
  logic [ADDR_WIDTH:0]  words_q;
  logic                 err_q;
  logic                 ready_q;
  logic                 busy_q;
  logic [31:0]          word_d;
  logic                 accept;
  logic                 full;
`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0]          sum_q;
`endif

  // A start in the same cycle wins over any byte, so it masks acceptance.
  assign accept = ready_q & load_valid_i & ~load_start_i;
  assign full   = words_q[ADDR_WIDTH];
  assign word_d = place_byte(word_q, load_byte_i, byte_cnt_q);

  // The write fires on the accepting edge, so it is decoded combinationally.
  assign we_o    = accept & ~full & ((byte_cnt_q == 2'd3) | load_last_i);
  assign waddr_o = words_q[ADDR_WIDTH-1:0];
  assign wdata_o = word_d;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= InstRomIdle;
      byte_cnt_q <= 2'd0;
      word_q     <= ZeroWord;
      words_q    <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
      sum_q      <= ZeroWord;
`endif
    end else if (load_start_i) begin
      state_q    <= InstRomLoad;
      byte_cnt_q <= 2'd0;
      word_q     <= ZeroWord;
      words_q    <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b1;
`ifdef INST_ROM_CHECKSUM_EN
      sum_q      <= ZeroWord;
`endif
    end else if (accept) begin
      if (full) begin
        state_q <= InstRomErr;
        err_q   <= 1'b1;
        ready_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        if (we_o) begin
          byte_cnt_q <= 2'd0;
          word_q     <= ZeroWord;
          words_q    <= words_q + (ADDR_WIDTH+1)'(1);
`ifdef INST_ROM_CHECKSUM_EN
          sum_q      <= sum_q + word_d;
`endif
        end else begin
          byte_cnt_q <= byte_cnt_q + 2'd1;
          word_q     <= word_d;
        end
        if (load_last_i) begin
          state_q <= InstRomIdle;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          if (byte_cnt_q != 2'd3) err_q <= 1'b1;
        end
      end
    end
  end

  assign load_ready_o = ready_q;
  assign load_busy_o  = busy_q;
  assign load_words_o = words_q;
  assign load_err_o   = err_q;
`ifdef INST_ROM_CHECKSUM_EN
  assign load_sum_o   = sum_q;
`endif

endmodule

// File: rtl/inst_rom.sv
// Instruction memory with a zero-latency fetch port and a byte-serial program loader.
// Define INST_ROM_CHECKSUM_EN to expose load_sum_o, a wrapping sum of loaded words.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = InstRomAddrWidth
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rom_ce_i,
  input  logic [31:0]         rom_addr_i,
  output logic [31:0]         rom_data_o,
  input  logic                load_start_i,
  input  logic                load_valid_i,
  input  logic [7:0]          load_byte_i,
  input  logic                load_last_i,
  output logic                load_ready_o,
  output logic                load_busy_o,
  output logic [ADDR_WIDTH:0] load_words_o,
`ifdef INST_ROM_CHECKSUM_EN
  output logic                load_err_o,
  output logic [31:0]         load_sum_o
`else
  output logic                load_err_o
`endif
);

  localparam int Depth = 1 << ADDR_WIDTH;

  logic [31:0]           mem_q [Depth];
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           wdata;
  logic                  unused_addr_bits;

  inst_rom_loader #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start_i),
    .load_valid_i (load_valid_i),
    .load_byte_i  (load_byte_i),
    .load_last_i  (load_last_i),
    .load_ready_o (load_ready_o),
    .load_busy_o  (load_busy_o),
    .load_words_o (load_words_o),
    .load_err_o   (load_err_o),
`ifdef INST_ROM_CHECKSUM_EN
    .load_sum_o   (load_sum_o),
`endif
    .we_o         (we),
    .waddr_o      (waddr),
    .wdata_o      (wdata)
  );

  // NOTE: the array has no reset; a reset only returns the loader to idle,
  // and a program already in memory survives it.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Byte offset and high address bits are don't-care; high addresses alias.
  assign rom_data_o = rom_ce_i ? mem_q[rom_addr_i[ADDR_WIDTH+1:2]] : ZeroWord;

  assign unused_addr_bits = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom.sv
// Self-checking bench for inst_rom: directed scenarios plus randomized loads
// compared against a byte-stream reference model.
module tb_inst_rom;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rom_ce_i = 1'b0;
  logic [31:0]   rom_addr_i = '0;
  logic [31:0]   rom_data_o;
  logic          load_start_i = 1'b0;
  logic          load_valid_i = 1'b0;
  logic [7:0]    load_byte_i = '0;
  logic          load_last_i = 1'b0;
  logic          load_ready_o;
  logic          load_busy_o;
  logic [AW:0]   load_words_o;
  logic          load_err_o;
`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0]   load_sum_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] model_mem   [DEPTH];
  bit          model_known [DEPTH];
  int          exp_words;
  bit          exp_err;
  bit          exp_busy;
  logic [31:0] exp_sum;

  inst_rom #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .load_start_i (load_start_i),
    .load_valid_i (load_valid_i),
    .load_byte_i  (load_byte_i),
    .load_last_i  (load_last_i),
    .load_ready_o (load_ready_o),
    .load_busy_o  (load_busy_o),
    .load_words_o (load_words_o),
`ifdef INST_ROM_CHECKSUM_EN
    .load_err_o   (load_err_o),
    .load_sum_o   (load_sum_o)
`else
    .load_err_o   (load_err_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Model: what a byte stream after a start leaves in memory and status.
  task automatic apply_model(input logic [7:0] bytes[$], input bit last);
    int n;
    int nw;
    logic [31:0] w;
    n  = bytes.size();
    exp_sum = 32'h0;
    if (n > DEPTH * 4) begin
      nw = DEPTH;
      exp_err = 1'b1;
      exp_busy = 1'b0;
      exp_words = DEPTH;
    end else begin
      nw = (last && (n % 4 != 0)) ? n / 4 + 1 : n / 4;
      exp_err = last && (n % 4 != 0);
      exp_busy = !last;
      exp_words = nw;
    end
    for (int k = 0; k < nw; k++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        w = (w << 8) | ((4 * k + j < n) ? 32'(bytes[4 * k + j]) : 32'h0);
      model_mem[k]   = w;
      model_known[k] = 1'b1;
      exp_sum        = exp_sum + w;
    end
  endtask

  task automatic drive_load(input logic [7:0] bytes[$], input bit last, input bit gaps);
    @(negedge clk);
    load_start_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
        @(negedge clk);
      end
      load_valid_i = 1'b1;
      load_byte_i  = bytes[i];
      load_last_i  = last && (i == bytes.size() - 1);
      @(negedge clk);
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] addr, input logic ce, output logic [31:0] data);
    rom_addr_i = addr;
    rom_ce_i   = ce;
    #1;
    data = rom_data_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({load_ready_o, load_busy_o, load_err_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: ready/busy/err=%b%b%b expected 000", load_ready_o, load_busy_o, load_err_o);
    end
    n_checks++;
    if (load_words_o !== '0) begin
      n_fail++;
      $display("FAIL reset_words: got %0d expected 0", load_words_o);
    end
`ifdef INST_ROM_CHECKSUM_EN
    n_checks++;
    if (load_sum_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_sum: got %h expected 00000000", load_sum_o);
    end
`endif
    read_word(32'h0, 1'b0, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ce_low: got %h expected 00000000", d);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] b[$];
    logic [31:0] d;
    b = '{8'h34, 8'h01, 8'h12, 8'h34};
    @(negedge clk);
    load_start_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
    n_checks++;
    if ({load_busy_o, load_ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL busy_after_start: busy/ready=%b%b expected 11", load_busy_o, load_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      load_valid_i = 1'b1;
      load_byte_i  = b[i];
      load_last_i  = (i == 3);
      @(negedge clk);
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    apply_model(b, 1'b1);
    read_word(32'h0, 1'b1, d);
    n_checks++;
    if (d !== 32'h34011234) begin
      n_fail++;
      $display("FAIL single_word_data: got %h expected 34011234", d);
    end
    n_checks++;
    if (load_words_o !== (AW+1)'(1) || load_err_o !== 1'b0 || load_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_word_status: words=%0d err=%b busy=%b expected 1 0 0",
               load_words_o, load_err_o, load_busy_o);
    end
  endtask

  task automatic test_two_word();
    logic [7:0] b[$];
    logic [31:0] d;
    b = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07};
    drive_load(b, 1'b1, 1'b0);
    apply_model(b, 1'b1);
    read_word(32'h0, 1'b1, d);
    n_checks++;
    if (d !== 32'h20010005) begin
      n_fail++;
      $display("FAIL two_word_w0: got %h expected 20010005", d);
    end
    read_word(32'h4, 1'b1, d);
    n_checks++;
    if (d !== 32'h20020007) begin
      n_fail++;
      $display("FAIL two_word_addr4: got %h expected 20020007", d);
    end
    read_word(32'h5, 1'b1, d);
    n_checks++;
    if (d !== 32'h20020007) begin
      n_fail++;
      $display("FAIL two_word_addr5: got %h expected 20020007", d);
    end
    read_word(32'hFFFF_FFF4, 1'b1, d);
    n_checks++;
    if (d !== 32'h20020007) begin
      n_fail++;
      $display("FAIL two_word_alias: got %h expected 20020007", d);
    end
    read_word(32'h4, 1'b0, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL two_word_ce_low: got %h expected 00000000", d);
    end
  endtask

  task automatic test_partial();
    logic [7:0] b[$];
    logic [31:0] d;
    b = '{8'hAB, 8'hCD};
    drive_load(b, 1'b1, 1'b0);
    apply_model(b, 1'b1);
    read_word(32'h0, 1'b1, d);
    n_checks++;
    if (d !== 32'hABCD0000) begin
      n_fail++;
      $display("FAIL partial_data: got %h expected abcd0000", d);
    end
    n_checks++;
    if (load_err_o !== 1'b1 || load_busy_o !== 1'b0 || load_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_status: err=%b busy=%b ready=%b expected 1 0 0",
               load_err_o, load_busy_o, load_ready_o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b[$];
    logic [31:0] d;
    b = {};
    for (int i = 0; i < DEPTH * 4 + 1; i++) b.push_back(8'($urandom));
    drive_load(b, 1'b0, 1'b0);
    apply_model(b, 1'b0);
    n_checks++;
    if (load_err_o !== 1'b1 || load_ready_o !== 1'b0 || load_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_status: err=%b ready=%b busy=%b expected 1 0 0",
               load_err_o, load_ready_o, load_busy_o);
    end
    n_checks++;
    if (load_words_o !== (AW+1)'(exp_words)) begin
      n_fail++;
      $display("FAIL overflow_words: got %0d expected %0d", load_words_o, exp_words);
    end
    for (int k = 0; k < DEPTH; k++) begin
      read_word(32'(k) << 2, 1'b1, d);
      n_checks++;
      if (d !== model_mem[k]) begin
        n_fail++;
        $display("FAIL overflow_mem[%0d]: got %h expected %h", k, d, model_mem[k]);
      end
    end
    // Extra bytes while in the error state must be ignored.
    load_valid_i = 1'b1;
    load_byte_i  = 8'h55;
    repeat (2) @(negedge clk);
    load_valid_i = 1'b0;
    n_checks++;
    if (load_words_o !== (AW+1)'(DEPTH) || load_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_state_hold: words=%0d ready=%b expected %0d 0", load_words_o, load_ready_o, DEPTH);
    end
    load_start_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
    n_checks++;
    if (load_err_o !== 1'b0 || load_busy_o !== 1'b1 || load_ready_o !== 1'b1 || load_words_o !== '0) begin
      n_fail++;
      $display("FAIL overflow_restart: err=%b busy=%b ready=%b words=%0d expected 0 1 1 0",
               load_err_o, load_busy_o, load_ready_o, load_words_o);
    end
  endtask

  task automatic test_restart_priority();
    logic [7:0] b[$];
    logic [31:0] d;
    b = '{8'hC0, 8'hFF, 8'hEE, 8'h01};
    @(negedge clk);
    load_start_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
    load_valid_i = 1'b1;
    load_byte_i  = 8'h11;
    @(negedge clk);
    load_byte_i  = 8'h22;
    @(negedge clk);
    // Byte presented together with a restart must be discarded.
    load_start_i = 1'b1;
    load_byte_i  = 8'h99;
    @(negedge clk);
    load_start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_byte_i = b[i];
      load_last_i = (i == 3);
      @(negedge clk);
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    apply_model(b, 1'b1);
    read_word(32'h0, 1'b1, d);
    n_checks++;
    if (d !== 32'hC0FFEE01) begin
      n_fail++;
      $display("FAIL restart_data: got %h expected c0ffee01", d);
    end
    n_checks++;
    if (load_words_o !== (AW+1)'(1) || load_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_status: words=%0d err=%b expected 1 0", load_words_o, load_err_o);
    end
  endtask

  task automatic test_read_during_write();
    logic [7:0] b[$];
    logic [31:0] d;
    logic [31:0] old_w;
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    old_w = model_mem[0];
    @(negedge clk);
    load_start_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid_i = 1'b1;
      load_byte_i  = b[i];
      @(negedge clk);
    end
    load_byte_i = b[3];
    load_last_i = 1'b1;
    read_word(32'h0, 1'b1, d);
    n_checks++;
    if (d !== old_w) begin
      n_fail++;
      $display("FAIL rdw_old: got %h expected %h", d, old_w);
    end
    @(negedge clk);
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    apply_model(b, 1'b1);
    read_word(32'h0, 1'b1, d);
    n_checks++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rdw_new: got %h expected deadbeef", d);
    end
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    logic [31:0] d;
    bit last;
    for (int it = 0; it < 10; it++) begin
      b = {};
      for (int i = 0, n = $urandom_range(1, DEPTH * 4 + 2); i < n; i++) b.push_back(8'($urandom));
      last = ($urandom_range(0, 4) != 0);
      drive_load(b, last, 1'b1);
      apply_model(b, last);
      n_checks++;
      if (load_words_o !== (AW+1)'(exp_words) || load_err_o !== exp_err ||
          load_busy_o !== exp_busy || load_ready_o !== exp_busy) begin
        n_fail++;
        $display("FAIL random_status[%0d]: words=%0d err=%b busy=%b ready=%b expected %0d %b %b %b",
                 it, load_words_o, load_err_o, load_busy_o, load_ready_o,
                 exp_words, exp_err, exp_busy, exp_busy);
      end
`ifdef INST_ROM_CHECKSUM_EN
      n_checks++;
      if (load_sum_o !== exp_sum) begin
        n_fail++;
        $display("FAIL random_sum[%0d]: got %h expected %h", it, load_sum_o, exp_sum);
      end
`endif
      for (int k = 0; k < DEPTH; k++) begin
        if (!model_known[k]) continue;
        read_word(($urandom & 32'hFFFF_FFF3) | (32'(k) << 2), 1'b1, d);
        n_checks++;
        if (d !== model_mem[k]) begin
          n_fail++;
          $display("FAIL random_mem[%0d][%0d]: got %h expected %h", it, k, d, model_mem[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] b[$];
    logic [31:0] d;
    logic [31:0] keep1;
    keep1 = model_mem[1];
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    drive_load(b, 1'b0, 1'b0);
    apply_model(b, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (load_busy_o !== 1'b0 || load_ready_o !== 1'b0 || load_words_o !== '0 || load_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_status: busy=%b ready=%b words=%0d err=%b expected 0 0 0 0",
               load_busy_o, load_ready_o, load_words_o, load_err_o);
    end
    @(negedge clk);
    rst = 1'b0;
    read_word(32'h0, 1'b1, d);
    n_checks++;
    if (d !== 32'h01020304) begin
      n_fail++;
      $display("FAIL reset_mid_w0: got %h expected 01020304", d);
    end
    read_word(32'h4, 1'b1, d);
    n_checks++;
    if (d !== keep1) begin
      n_fail++;
      $display("FAIL reset_mid_w1: got %h expected %h", d, keep1);
    end
  endtask

`ifdef INST_ROM_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] b[$];
    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};
    drive_load(b, 1'b1, 1'b0);
    apply_model(b, 1'b1);
    n_checks++;
    if (load_sum_o !== 32'h00000001) begin
      n_fail++;
      $display("FAIL checksum_wrap: got %h expected 00000001", load_sum_o);
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      model_mem[k]   = 32'h0;
      model_known[k] = 1'b0;
    end
    test_reset();
    test_single_word();
    test_two_word();
    test_partial();
    test_overflow();
    test_restart_priority();
    test_read_during_write();
    test_random();
    test_two_word();
    test_reset_mid_load();
`ifdef INST_ROM_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
